// File: rtl/mx_pkg.sv
// mx_pkg: shared MXINT8 widths, E8M0/int8 code points and packer state encoding.
package mx_pkg;
   localparam int SCALE_WIDTH = 8;
   localparam int MXINT8_ELEMENT_WIDTH = 8;
   localparam int BLOCK_SIZE = 32;
   localparam logic [7:0] E8M0_NAN = 8'hFF;
   localparam logic [7:0] E8M0_MAX = 8'hFE;
   localparam logic signed [7:0] MXINT8_MAX = 8'sd127;
   localparam logic [7:0] MXINT8_UNUSED = 8'h80;
   typedef enum logic [1:0] {COLLECT, NORM, EMIT} t_packer_state;
endpackage

// File: rtl/mxint8_block_packer_elem_round.sv
// mxint8_elem_round: arithmetic right shift with round-half-away-from-zero, saturated to [-127,127].
module mxint8_elem_round
   import mx_pkg::*;
#(
   parameter int IN_W = 10,
   parameter int SHIFT_W = 2
) (
   input  logic [IN_W-1:0]                 v,
   input  logic [SHIFT_W-1:0]              s,
   output logic [MXINT8_ELEMENT_WIDTH-1:0] q
);
   logic neg;
   logic [IN_W:0] mag;
   logic [IN_W:0] half;
   logic [IN_W:0] rnd;
   logic [7:0] sat;
   logic [7:0] res;
   always_comb begin
      neg  = v[IN_W-1];
      mag  = neg ? (~{1'b1, v} + 1'b1) : {1'b0, v};
      half = (s == '0) ? '0 : ((IN_W+1)'(1) << (s - 1'b1));
      rnd  = (mag + half) >> s;
      sat  = (rnd > (IN_W+1)'(MXINT8_MAX)) ? MXINT8_MAX : rnd[7:0];
      res  = neg ? -sat : sat;
      q    = (res == MXINT8_UNUSED) ? (res | 8'h01) : res;
   end
endmodule

// File: rtl/mxint8_block_packer.sv
// mxint8_block_packer: buffers one block of widened sums, renormalises to int8 and emits a packed MXINT8 vector.
module mxint8_block_packer
   import mx_pkg::*;
#(
   parameter int BLOCK_SIZE = mx_pkg::BLOCK_SIZE,
   parameter int IN_W = 10,
   parameter int SHIFT_W = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [IN_W-1:0]                            in_element,
   input  logic [SCALE_WIDTH-1:0]                     in_scale,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [SCALE_WIDTH-1:0]                     out_scale,
   output logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] out_elements,
   output logic [SHIFT_W-1:0]                         out_shift
);
   localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int M_W = IN_W - 7;
   t_packer_state state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [M_W-1:0] mask_q, mask_d;
   logic [SCALE_WIDTH-1:0] scale_q, scale_d;
   logic [IN_W-1:0] buf_q [BLOCK_SIZE];
   logic [IN_W-1:0] buf_d [BLOCK_SIZE];
   logic in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d;
   logic [SCALE_WIDTH-1:0] out_scale_q, out_scale_d;
   logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] out_elements_q, out_elements_d;
   logic [SHIFT_W-1:0] out_shift_q, out_shift_d;
   logic [SHIFT_W-1:0] shift;
   logic [8:0] sum9;
   logic last;
   logic [MXINT8_ELEMENT_WIDTH-1:0] rounded [BLOCK_SIZE];

   for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_round
      mxint8_elem_round #(.IN_W(IN_W), .SHIFT_W(SHIFT_W)) u_round (
         .v(buf_q[g]),
         .s(shift),
         .q(rounded[g])
      );
   end

   // Mask bit j flags an element whose bit 7+j differs from its sign, so s is one past the highest set bit.
   always_comb begin
      shift = '0;
      for (int j = 0; j < M_W; j++) if (mask_q[j]) shift = SHIFT_W'(j + 1);
   end

   assign sum9 = {1'b0, scale_q} + 9'(shift);
   assign last = cnt_q == CNT_W'(BLOCK_SIZE - 1);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mask_d         = mask_q;
      scale_d        = scale_q;
      buf_d          = buf_q;
      in_ready_d     = in_ready_q;
      out_valid_d    = out_valid_q;
      out_scale_d    = out_scale_q;
      out_elements_d = out_elements_q;
      out_shift_d    = out_shift_q;
      if (state_q == COLLECT && in_valid) begin
         buf_d[cnt_q] = in_element;
         mask_d       = ((cnt_q == '0) ? '0 : mask_q) | (in_element[IN_W-1:7] ^ {M_W{in_element[IN_W-1]}});
         scale_d      = (cnt_q == '0) ? in_scale : scale_q;
         cnt_d        = last ? '0 : cnt_q + 1'b1;
         state_d      = last ? NORM : COLLECT;
         in_ready_d   = !last;
      end
      if (state_q == NORM) begin
         for (int i = 0; i < BLOCK_SIZE; i++) out_elements_d[8*i +: 8] = rounded[i];
         out_shift_d = shift;
         out_scale_d = (scale_q == E8M0_NAN || sum9 > {1'b0, E8M0_MAX}) ? E8M0_NAN : sum9[7:0];
         out_valid_d = 1'b1;
         state_d     = EMIT;
      end
      if (state_q == EMIT && out_ready) begin
         out_valid_d = 1'b0;
         in_ready_d  = 1'b1;
         state_d     = COLLECT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= COLLECT;
         cnt_q          <= '0;
         mask_q         <= '0;
         scale_q        <= '0;
         in_ready_q     <= 1'b1;
         out_valid_q    <= 1'b0;
         out_scale_q    <= '0;
         out_elements_q <= '0;
         out_shift_q    <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mask_q         <= mask_d;
         scale_q        <= scale_d;
         in_ready_q     <= in_ready_d;
         out_valid_q    <= out_valid_d;
         out_scale_q    <= out_scale_d;
         out_elements_q <= out_elements_d;
         out_shift_q    <= out_shift_d;
      end
   end

   always_ff @(posedge clk) buf_q <= buf_d;

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_scale    = out_scale_q;
   assign out_elements = out_elements_q;
   assign out_shift    = out_shift_q;
endmodule

// File: tb/tb_mxint8_block_packer.sv
// tb_mxint8_block_packer: directed vector table, corner sequences and randomized blocks against an arithmetic model.
module tb_mxint8_block_packer;
   localparam int BS = 32;
   localparam int IN_W = 10;
   localparam int SHIFT_W = 2;
   typedef int blk_t [BS];
   typedef struct {
      int base; int ia; int va; int ib; int vb; int scale; int bp;
      int e_sh; int e_sc; int e_base; int e_a; int e_b;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [IN_W-1:0] in_element = '0;
   logic [7:0] in_scale = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [7:0] out_scale;
   logic [BS*8-1:0] out_elements;
   logic [SHIFT_W-1:0] out_shift;
   int n_pass = 0;
   int n_total = 0;
   vec_t vecs [8];

   mxint8_block_packer #(.BLOCK_SIZE(BS), .IN_W(IN_W), .SHIFT_W(SHIFT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_element(in_element), .in_scale(in_scale),
      .out_valid(out_valid), .out_ready(out_ready), .out_scale(out_scale),
      .out_elements(out_elements), .out_shift(out_shift)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [BS*8-1:0] got, input logic [BS*8-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   function automatic blk_t mk(input int base, input int ia, input int va, input int ib, input int vb);
      blk_t b;
      for (int i = 0; i < BS; i++) b[i] = (i == ia) ? va : (i == ib) ? vb : base;
      return b;
   endfunction

   function automatic logic [BS*8-1:0] pack(input blk_t b);
      logic [BS*8-1:0] p;
      for (int i = 0; i < BS; i++) p[8*i +: 8] = 8'(b[i]);
      return p;
   endfunction

   // Reference: smallest s whose (8+s)-bit signed range holds every value, then integer round-half-away.
   task automatic model(input blk_t v, input int scale, output logic [BS*8-1:0] el, output int sc, output int sh);
      sh = IN_W - 8;
      for (int s = IN_W - 8; s >= 0; s--) begin
         bit ok = 1;
         for (int i = 0; i < BS; i++) if (v[i] < -(1 << (7 + s)) || v[i] >= (1 << (7 + s))) ok = 0;
         if (ok) sh = s;
      end
      for (int i = 0; i < BS; i++) begin
         int m, r;
         m = (v[i] < 0) ? -v[i] : v[i];
         r = (sh == 0) ? m : (m + (1 << (sh - 1))) / (1 << sh);
         if (r > 127) r = 127;
         el[8*i +: 8] = 8'((v[i] < 0) ? -r : r);
      end
      sc = (scale == 255 || scale + sh > 254) ? 255 : scale + sh;
   endtask

   task automatic send_block(input blk_t vals, input int scale, input bit gaps, input string tag);
      int i = 0;
      int guard = 0;
      int w = 0;
      logic rdy;
      while (i < BS && guard < 500) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_element = IN_W'($urandom);
            in_scale = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_element = IN_W'(vals[i]);
            in_scale = (i == 0) ? 8'(scale) : 8'($urandom);
         end
         rdy = in_ready;
         @(posedge clk);
         if (in_valid && rdy) i++;
      end
      if (i != BS) chk({tag, ".send_timeout"}, BS'(i), BS'(BS));
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, ".lat_norm"}, out_valid, 1'b0);
      @(negedge clk);
      chk({tag, ".lat_emit"}, out_valid, 1'b1);
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
   endtask

   task automatic recv_block(input logic [BS*8-1:0] ee, input int esc, input int esh, input int bp, input string tag);
      logic [BS*8-1:0] snap;
      logic [7:0] snap_sc;
      chk({tag, ".elems"}, out_elements, ee);
      chk({tag, ".scale"}, out_scale, esc);
      chk({tag, ".shift"}, out_shift, esh);
      snap = out_elements;
      snap_sc = out_scale;
      for (int k = 0; k < bp; k++) begin
         in_valid = 1'b1;
         in_element = IN_W'($urandom);
         @(negedge clk);
         chk({tag, ".hold_ctl"}, {in_ready, out_valid}, 2'b01);
         chk({tag, ".hold_data"}, {out_scale, out_elements[BS*8-9:0]}, {snap_sc, snap[BS*8-9:0]});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".release"}, {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      vecs[0] = '{10, -1, 0, -1, 0, 127, 0, 0, 127, 10, 0, 0};
      vecs[1] = '{3, 0, 200, -1, 0, 100, 5, 1, 101, 2, 100, 0};
      vecs[2] = '{-3, 5, 511, 6, -512, 10, 0, 2, 12, -1, 127, -127};
      vecs[3] = '{0, 0, 300, -1, 0, 254, 0, 2, 255, 0, 75, 0};
      vecs[4] = '{1, -1, 0, -1, 0, 255, 1, 0, 255, 1, 0, 0};
      vecs[5] = '{-128, -1, 0, -1, 0, 5, 0, 0, 5, -127, 0, 0};
      vecs[6] = '{0, 0, 200, -1, 0, 253, 2, 1, 254, 0, 100, 0};
      vecs[7] = '{0, 0, 200, -1, 0, 254, 0, 1, 255, 0, 100, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset.ctl", {in_ready, out_valid}, 2'b10);
      chk("reset.scale", out_scale, 0);
      chk("reset.elems", out_elements, 0);
      chk("reset.shift", out_shift, 0);

      for (int t = 0; t < 8; t++) begin
         string tag;
         tag = $sformatf("vec%0d", t);
         send_block(mk(vecs[t].base, vecs[t].ia, vecs[t].va, vecs[t].ib, vecs[t].vb), vecs[t].scale, 1'b0, tag);
         recv_block(pack(mk(vecs[t].e_base, vecs[t].ia, vecs[t].e_a, vecs[t].ib, vecs[t].e_b)),
                    vecs[t].e_sc, vecs[t].e_sh, vecs[t].bp, tag);
      end

      // Reset after ten accepted elements: the partial block must vanish.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_element = IN_W'(99);
         in_scale = 8'd200;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_block(mk(7, -1, 0, -1, 0), 50, 1'b0, "midrst");
      recv_block(pack(mk(7, -1, 0, -1, 0)), 50, 0, 0, "midrst");

      // Reset while a block is pending on the output drops it.
      send_block(mk(5, -1, 0, -1, 0), 3, 1'b0, "emitrst");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("emitrst.ctl", {in_ready, out_valid}, 2'b10);
      chk("emitrst.scale", out_scale, 0);
      chk("emitrst.elems", out_elements, 0);

      for (int r = 0; r < 25; r++) begin
         blk_t v;
         int lim, sc, esc, esh, sel;
         logic [BS*8-1:0] ee;
         sel = int'($urandom_range(0, 3));
         lim = (sel == 0) ? 127 : (sel == 1) ? 255 : (sel == 2) ? 511 : 40;
         for (int i = 0; i < BS; i++) v[i] = int'($urandom_range(0, 2 * lim + 1)) - lim - 1;
         sel = int'($urandom_range(0, 9));
         sc = (sel == 0) ? 255 : (sel == 1) ? 254 : (sel == 2) ? 253 : int'($urandom_range(0, 255));
         model(v, sc, ee, esc, esh);
         send_block(v, sc, 1'b1, "rnd");
         recv_block(ee, esc, esh, int'($urandom_range(0, 3)), "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
